period_abs_sum_framer: RTL and testbench

- Sequential front end of the detection energy path. Accepts a stream of signed 8-bit samples, packs them into 128-bit period words of 16 samples, and accumulates each word's absolute sum over a detection window of PERIODS words.
- Drives the 128-bit period word and running sum into the combinational abs-sum calculator sub-module and captures its updated sum.
- Emits one window total per detection window on a valid/ready output to the threshold/decision logic.

---
 rtl/period_abs_sum_framer_pkg.sv | 19 +
 rtl/period_abs_sum_framer.sv | 102 ++++++++++
 tb/tb_period_abs_sum_framer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/period_abs_sum_framer_pkg.sv
// Shared detection-path types and constants.
// Sample/sum typedefs and the framer state encoding.
package period_abs_sum_framer_pkg;

  localparam int SAMPLE_W     = 8;
  localparam int WORD_SAMPLES = 16;
  localparam int SUM_W        = 32;
  localparam int WORD_W       = SAMPLE_W * WORD_SAMPLES;

  typedef enum logic [1:0] {
    FILL,
    ACCUM,
    OUT
  } state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]    sum_t;

endpackage

// File: rtl/period_abs_sum_framer.sv
// Packs signed samples into 128-bit period words and
// accumulates per-window absolute sums via an external calculator.
module period_abs_sum_framer
  import period_abs_sum_framer_pkg::*;
#(
  parameter int PERIODS = 64,
  parameter int SUM_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [7:0]       s_data,
  input  logic                    s_last,
  output logic [127:0]            period_data,
  output logic signed [SUM_W-1:0] cur_abs_sum,
  input  logic signed [SUM_W-1:0] updated_abs_sum,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [SUM_W-1:0] m_sum,
  output logic [CNT_W-1:0]        m_periods
);

  state_t                  state, state_n;
  logic [3:0]              idx;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    last_q;
  logic                    done;
  logic                    accept;
  logic signed [SUM_W-1:0] acc;

  assign cnt_inc     = cnt + 1'b1;
  assign done        = (cnt_inc == CNT_W'(PERIODS)) || last_q;
  assign accept      = s_valid && s_ready;
  assign cur_abs_sum = acc;

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && (idx == 4'd15 || s_last))
          state_n = ACCUM;
      end
      ACCUM: state_n = done ? OUT : FILL;
      OUT: begin
        m_valid = 1'b1;
        if (m_ready)
          state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  // Unwritten bytes stay zero because the word is cleared leaving ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      idx         <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      acc         <= '0;
      period_data <= '0;
      m_sum       <= '0;
      m_periods   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        FILL: begin
          if (accept) begin
            period_data[{idx, 3'b000} +: 8] <= s_data;
            idx    <= idx + 4'd1;
            last_q <= s_last;
          end
        end
        ACCUM: begin
          acc         <= updated_abs_sum;
          cnt         <= cnt_inc;
          idx         <= '0;
          last_q      <= 1'b0;
          period_data <= '0;
          if (done) begin
            m_sum     <= updated_abs_sum;
            m_periods <= cnt_inc;
          end
        end
        OUT: begin
          if (m_ready) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_period_abs_sum_framer.sv
// Directed bench for period_abs_sum_framer, four PERIODS
// variants sharing one stimulus bus with a behavioural calculator.
module tb_period_abs_sum_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;
  int         sel = 0;

  logic               sr_a  [4];
  logic               mv_a  [4];
  logic [127:0]       pd_a  [4];
  logic signed [31:0] cur_a [4];
  logic signed [31:0] ms_a  [4];
  logic [15:0]        mp_a  [4];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : u
    logic               sr, mv, sv, mr;
    logic [127:0]       pd;
    logic signed [31:0] cur, upd, ms;
    logic [15:0]        mp;

    assign sv = s_valid && (sel == g);
    assign mr = m_ready && (sel == g);

    period_abs_sum_framer #(.PERIODS(g + 1)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_valid         (sv),
      .s_ready         (sr),
      .s_data          (s_data),
      .s_last          (s_last),
      .period_data     (pd),
      .cur_abs_sum     (cur),
      .updated_abs_sum (upd),
      .m_valid         (mv),
      .m_ready         (mr),
      .m_sum           (ms),
      .m_periods       (mp)
    );

    always_comb begin
      int s;
      s = iabs(int'(cur));
      for (int k = 0; k < 16; k++)
        s = s + iabs(int'($signed(pd[8*k +: 8])));
      upd = s;
    end

    assign sr_a[g]  = sr;
    assign mv_a[g]  = mv;
    assign pd_a[g]  = pd;
    assign cur_a[g] = cur;
    assign ms_a[g]  = ms;
    assign mp_a[g]  = mp;
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept.
  task automatic push(input int s, input int d, input logic l);
    int t;
    t = 0;
    sel = s;
    s_data = 8'(d);
    s_last = l;
    s_valid = 1'b1;
    while (!sr_a[s] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("push_rdy", 128'(sr_a[s]), 128'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_result(input int s, output int w);
    w = 0;
    while (!mv_a[s] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("result_timeout", 128'(mv_a[s]), 128'd1);
  endtask

  typedef struct {
    int           s;
    int           n;
    int           a;
    int           b;
    bit           last;
    int           exp_sum;
    int           exp_per;
    bit           chk_pd;
    logic [127:0] exp_pd;
  } vec_t;

  vec_t v [7];

  initial begin
    int w;
    int e;
    int d;

    v[0] = '{1, 32,    1,   1, 1'b0,   32, 2, 1'b0, 128'h0};
    v[1] = '{0, 16, -128, 127, 1'b0, 2040, 1, 1'b1, {8{16'h7F80}}};
    v[2] = '{3, 20,   -3,  -3, 1'b1,   60, 2, 1'b1, 128'hFDFDFDFD};
    v[3] = '{0, 16,   10, -20, 1'b0,  240, 1, 1'b0, 128'h0};
    v[4] = '{3, 16,   -1,  -1, 1'b1,   16, 1, 1'b1, {16{8'hFF}}};
    v[5] = '{2,  1,   -7,  -7, 1'b1,    7, 1, 1'b1, 128'hF9};
    v[6] = '{1, 17,    2,  -2, 1'b1,   34, 2, 1'b0, 128'h0};

    repeat (2) @(negedge clk);
    chk("rst_s_ready", 128'(sr_a[0]), 128'd1);
    chk("rst_m_valid", 128'(mv_a[0]), 128'd0);
    chk("rst_m_sum", 128'(ms_a[3]), 128'd0);
    chk("rst_m_periods", 128'(mp_a[3]), 128'd0);
    chk("rst_period_data", pd_a[1], 128'd0);
    chk("rst_cur_sum", 128'(cur_a[2]), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      sel = v[i].s;
      m_ready = 1'b1;
      for (int k = 0; k < v[i].n; k++)
        push(v[i].s, (k % 2) ? v[i].b : v[i].a,
             v[i].last && (k == v[i].n - 1));
      if (v[i].chk_pd)
        chk($sformatf("v%0d_word", i), pd_a[sel], v[i].exp_pd);
      chk($sformatf("v%0d_mv_early", i), 128'(mv_a[sel]), 128'd0);
      wait_result(sel, w);
      chk($sformatf("v%0d_latency", i), 128'(w), 128'd1);
      chk($sformatf("v%0d_sum", i), 128'(ms_a[sel]),
          128'(v[i].exp_sum));
      chk($sformatf("v%0d_periods", i), 128'(mp_a[sel]),
          128'(v[i].exp_per));
      @(negedge clk);
      chk($sformatf("v%0d_mv_drop", i), 128'(mv_a[sel]), 128'd0);
    end

    // Output stall with m_ready low
    sel = 0;
    m_ready = 1'b0;
    for (int k = 0; k < 16; k++) push(0, 9, 1'b0);
    wait_result(0, w);
    for (int k = 0; k < 10; k++) begin
      chk("stall_mv", 128'(mv_a[0]), 128'd1);
      chk("stall_s_ready", 128'(sr_a[0]), 128'd0);
      chk("stall_sum", 128'(ms_a[0]), 128'd144);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_mv", 128'(mv_a[0]), 128'd0);
    chk("stall_acc_clear", 128'(cur_a[0]), 128'd0);
    chk("stall_ready_back", 128'(sr_a[0]), 128'd1);
    for (int k = 0; k < 16; k++) push(0, 1, 1'b0);
    wait_result(0, w);
    chk("after_stall_sum", 128'(ms_a[0]), 128'd16);
    @(negedge clk);

    // Reset in the middle of a window
    for (int k = 0; k < 9; k++) push(0, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_cur", 128'(cur_a[0]), 128'd0);
    chk("midrst_word", pd_a[0], 128'd0);
    chk("midrst_ready", 128'(sr_a[0]), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_mv", 128'(mv_a[0]), 128'd0);
    end
    for (int k = 0; k < 16; k++) push(0, 5, 1'b0);
    wait_result(0, w);
    chk("midrst_next_sum", 128'(ms_a[0]), 128'd80);
    chk("midrst_next_per", 128'(mp_a[0]), 128'd1);
    @(negedge clk);

    // Random data with random input gaps
    e = 0;
    for (int k = 0; k < 48; k++) begin
      d = int'($urandom_range(0, 255));
      e = e + iabs(int'($signed(8'(d))));
      push(2, d, 1'b0);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    wait_result(2, w);
    chk("rand_sum", 128'(ms_a[2]), 128'(e));
    chk("rand_periods", 128'(mp_a[2]), 128'd3);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
